// File: rtl/store_pkg.sv
// Shared encodings for the store sequencer: store-size codes, FSM state
// encoding and the wait-counter width.
// Ports: none (package).
package store_pkg;

  // Store size as decoded from the instruction funct3 field.
  typedef enum logic [1:0] {
    SS_WORD = 2'b00,
    SS_BYTE = 2'b01,
    SS_HALF = 2'b10,
    SS_ILL  = 2'b11
  } ss_type_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Wide enough for READ_LAT-1 with READ_LAT up to 7.
  localparam int CNT_W = 3;

endpackage

// File: rtl/ss_merge.sv
// Purpose: combinational merge of a store operand into the old memory word.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: old_word (word read from memory), b_data (register B),
//        ss_type (store size), wdata (word to write back).
module ss_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] b_data,
  input  ss_type_e    ss_type,
  output logic [31:0] wdata
);

  // Partial stores always land in the low bits; the byte offset in the
  // address is not decoded.
  always_comb begin
    wdata = b_data;
    case (ss_type)
      SS_BYTE: wdata = {old_word[31:8], b_data[7:0]};
      SS_HALF: wdata = {old_word[31:16], b_data[15:0]};
      default: wdata = b_data;
    endcase
  end

endmodule

// File: rtl/store_sequencer.sv
// Purpose: sequences sw/sh/sb stores; partial stores do read-modify-write.
// Latency: word 2 cycles to done, byte/half 3+READ_LAT, illegal 1.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
// Ports: clk, reset (sync, active-high); start/ss_type/addr/b_in request;
//        mem_rdata/mem_addr/mem_wdata/mem_wr memory port; busy/done/err status.
module store_sequencer
  import store_pkg::*;
#(
  parameter int unsigned READ_LAT = 1  // legal 1..7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  ss_type,
  input  logic [31:0] addr,
  input  logic [31:0] b_in,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_e             state_q;
  state_e             state_d;
  logic [31:0]        addr_q;
  logic [31:0]        b_q;
  ss_type_e           type_q;
  logic [31:0]        old_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic [31:0]        merged;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (ss_type)
            SS_WORD:          state_d = ST_WRITE;
            SS_BYTE, SS_HALF: state_d = ST_READ;
            default:          state_d = ST_DONE;
          endcase
        end
      end
      ST_READ:  state_d = ST_WAIT;
      ST_WAIT:  if (cnt_q == '0) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request latches, wait counter and old-word capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      b_q    <= '0;
      type_q <= SS_WORD;
      old_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q <= addr;
            b_q    <= b_in;
            type_q <= ss_type_e'(ss_type);
            err_q  <= (ss_type == SS_ILL);
          end
        end
        ST_READ: cnt_q <= CNT_LOAD;
        ST_WAIT: begin
          // The counter reaching zero marks the cycle the read data is valid.
          if (cnt_q == '0) begin
            old_q <= mem_rdata;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  ss_merge u_merge (
    .old_word (old_q),
    .b_data   (b_q),
    .ss_type  (type_q),
    .wdata    (merged)
  );

  // Outputs decode only registered state, so there is no input-to-output path.
  assign mem_addr  = addr_q;
  assign mem_wr    = (state_q == ST_WRITE);
  assign mem_wdata = mem_wr ? merged : 32'h0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = done & err_q;

endmodule

// File: tb/tb_store_sequencer.sv
// Bench for store_sequencer: READ_LAT=1 instance driven from a cycle table,
// READ_LAT=3 instance driven by hand-written multi-cycle sequences.
// Memory model returns the stored word only in the cycle the read completes.
module tb_store_sequencer;

  localparam logic [31:0] MEMW = 32'h1122_3344;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start3;
  logic [1:0]  ty;
  logic [31:0] a, b;
  logic [31:0] rdata1, rdata3, addr1, addr3, wd1, wd3;
  logic        wr1, wr3, busy1, busy3, done1, done3, err1, err3;

  always #5 clk = ~clk;

  store_sequencer #(.READ_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .ss_type(ty), .addr(a), .b_in(b),
    .mem_rdata(rdata1), .mem_addr(addr1), .mem_wdata(wd1), .mem_wr(wr1),
    .busy(busy1), .done(done1), .err(err1)
  );

  store_sequencer #(.READ_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .ss_type(ty), .addr(a), .b_in(b),
    .mem_rdata(rdata3), .mem_addr(addr3), .mem_wdata(wd3), .mem_wr(wr3),
    .busy(busy3), .done(done3), .err(err3)
  );

  // A read request is the first busy cycle with no write; data appears
  // exactly READ_LAT cycles later and is junk at every other time.
  logic [7:0] rq1, rq3;
  logic       busy1_d, busy3_d;
  always @(posedge clk) begin
    if (reset) begin
      rq1 <= '0; rq3 <= '0; busy1_d <= 1'b0; busy3_d <= 1'b0;
    end else begin
      busy1_d <= busy1;
      busy3_d <= busy3;
      rq1 <= {rq1[6:0], busy1 & ~busy1_d & ~wr1};
      rq3 <= {rq3[6:0], busy3 & ~busy3_d & ~wr3};
    end
  end
  assign rdata1 = rq1[0] ? MEMW : JUNK;
  assign rdata3 = rq3[2] ? MEMW : JUNK;

  int n_cmp = 0;
  int n_fail = 0;

  // Observed bundle: {mem_wr, busy, done, err, mem_addr, mem_wdata}.
  function automatic logic [67:0] obs1();
    return {wr1, busy1, done1, err1, addr1, wd1};
  endfunction
  function automatic logic [67:0] obs3();
    return {wr3, busy3, done3, err3, addr3, wd3};
  endfunction

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got wr/busy/done/err=%b addr=%h wdata=%h, expected wr/busy/done/err=%b addr=%h wdata=%h",
               name, act[67:64], act[63:32], act[31:0], exp[67:64], exp[63:32], exp[31:0]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        st;
    logic [1:0]  ty;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  flags;  // expected {wr, busy, done, err}
    logic [31:0] e_addr;
    logic [31:0] e_wd;
  } vec_t;

  localparam int NV = 25;
  vec_t vt [NV];

  initial begin
    // Word store
    vt[0]  = '{1'b1, 2'b00, 32'h40,  32'hDEADBEEF, 4'b0000, 32'h0,   32'h0};
    vt[1]  = '{1'b0, 2'b01, 32'h0,   32'h0,        4'b1100, 32'h40,  32'hDEADBEEF};
    vt[2]  = '{1'b0, 2'b00, 32'h0,   32'h0,        4'b0110, 32'h40,  32'h0};
    vt[3]  = '{1'b0, 2'b00, 32'h0,   32'h0,        4'b0000, 32'h40,  32'h0};
    // Byte store, READ_LAT=1
    vt[4]  = '{1'b1, 2'b01, 32'h80,  32'hAABBCCDD, 4'b0000, 32'h40,  32'h0};
    vt[5]  = '{1'b0, 2'b00, 32'h0,   32'h0,        4'b0100, 32'h80,  32'h0};
    vt[6]  = '{1'b0, 2'b00, 32'h0,   32'h0,        4'b0100, 32'h80,  32'h0};
    vt[7]  = '{1'b0, 2'b00, 32'h0,   32'h0,        4'b1100, 32'h80,  32'h112233DD};
    vt[8]  = '{1'b0, 2'b00, 32'h0,   32'h0,        4'b0110, 32'h80,  32'h0};
    vt[9]  = '{1'b0, 2'b00, 32'h0,   32'h0,        4'b0000, 32'h80,  32'h0};
    // Illegal type
    vt[10] = '{1'b1, 2'b11, 32'hC0,  32'h12345678, 4'b0000, 32'h80,  32'h0};
    vt[11] = '{1'b0, 2'b00, 32'h0,   32'h0,        4'b0111, 32'hC0,  32'h0};
    vt[12] = '{1'b0, 2'b00, 32'h0,   32'h0,        4'b0000, 32'hC0,  32'h0};
    // Two byte stores with start held high
    vt[13] = '{1'b1, 2'b01, 32'h100, 32'hEE,       4'b0000, 32'hC0,  32'h0};
    vt[14] = '{1'b1, 2'b01, 32'h100, 32'hEE,       4'b0100, 32'h100, 32'h0};
    vt[15] = '{1'b1, 2'b01, 32'h100, 32'hEE,       4'b0100, 32'h100, 32'h0};
    vt[16] = '{1'b1, 2'b01, 32'h100, 32'hEE,       4'b1100, 32'h100, 32'h112233EE};
    vt[17] = '{1'b1, 2'b00, 32'h200, 32'h55555555, 4'b0110, 32'h100, 32'h0};
    vt[18] = '{1'b1, 2'b01, 32'h104, 32'h77,       4'b0000, 32'h100, 32'h0};
    vt[19] = '{1'b1, 2'b10, 32'h300, 32'h0,        4'b0100, 32'h104, 32'h0};
    vt[20] = '{1'b0, 2'b00, 32'h0,   32'h0,        4'b0100, 32'h104, 32'h0};
    vt[21] = '{1'b0, 2'b00, 32'h0,   32'h0,        4'b1100, 32'h104, 32'h11223377};
    vt[22] = '{1'b1, 2'b01, 32'h400, 32'h0,        4'b0110, 32'h104, 32'h0};
    vt[23] = '{1'b0, 2'b00, 32'h0,   32'h0,        4'b0000, 32'h104, 32'h0};
    vt[24] = '{1'b0, 2'b00, 32'h0,   32'h0,        4'b0000, 32'h104, 32'h0};

    reset = 1'b1; start1 = 1'b0; start3 = 1'b0; ty = 2'b00; a = '0; b = '0;
    repeat (2) cyc();
    @(negedge clk);
    chk("reset_dut1", obs1(), 68'h0);
    chk("reset_dut3", obs3(), 68'h0);
    cyc();
    reset = 1'b0;

    // Table-driven run on the READ_LAT=1 instance; one row per cycle.
    for (int i = 0; i < NV; i++) begin
      start1 = vt[i].st; ty = vt[i].ty; a = vt[i].a; b = vt[i].b;
      @(negedge clk);
      chk($sformatf("vec%0d", i), obs1(), {vt[i].flags, vt[i].e_addr, vt[i].e_wd});
      cyc();
    end
    start1 = 1'b0;

    // Halfword store, READ_LAT=3, with inputs changed after accept.
    start3 = 1'b1; ty = 2'b10; a = 32'h44; b = 32'hAABBCCDD;
    @(negedge clk); chk("half_c0", obs3(), 68'h0);
    cyc();
    start3 = 1'b0; ty = 2'b00; a = 32'hFFC; b = 32'h0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("half_c%0d", c), obs3(), {4'b0100, 32'h44, 32'h0});
      cyc();
    end
    @(negedge clk); chk("half_c5_write", obs3(), {4'b1100, 32'h44, 32'h1122CCDD});
    cyc();
    @(negedge clk); chk("half_c6_done", obs3(), {4'b0110, 32'h44, 32'h0});
    cyc();
    @(negedge clk); chk("half_c7_idle", obs3(), {4'b0000, 32'h44, 32'h0});
    cyc();

    // Reset during WAIT abandons the store.
    start3 = 1'b1; ty = 2'b01; a = 32'h50; b = 32'h99;
    cyc();
    start3 = 1'b0;
    cyc();                                  // cycle 2: WAIT
    @(negedge clk); chk("rst_pre_wait", obs3(), {4'b0100, 32'h50, 32'h0});
    cyc();                                  // cycle 3: WAIT, reset asserted
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk); chk("rst_after", obs3(), 68'h0);
    for (int c = 0; c < 5; c++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("rst_quiet%0d", c), obs3(), 68'h0);
    end
    cyc();

    // Reset and start in the same cycle: nothing is latched.
    reset = 1'b1; start3 = 1'b1; ty = 2'b00; a = 32'h60; b = 32'h1234;
    cyc();
    reset = 1'b0; start3 = 1'b0;
    @(negedge clk); chk("rst_start_same", obs3(), 68'h0);
    cyc();

    // Word store after the abandoned one completes normally.
    start3 = 1'b1; ty = 2'b00; a = 32'h48; b = 32'hCAFEF00D;
    cyc();
    start3 = 1'b0; b = 32'h0;
    @(negedge clk); chk("post_rst_write", obs3(), {4'b1100, 32'h48, 32'hCAFEF00D});
    cyc();
    @(negedge clk); chk("post_rst_done", obs3(), {4'b0110, 32'h48, 32'h0});
    cyc();
    @(negedge clk); chk("post_rst_idle", obs3(), {4'b0000, 32'h48, 32'h0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/store_sequencer.md
# store_sequencer

Multi-cycle controller that executes sw/sh/sb stores against the word-wide data memory of the multicycle CPU. For partial stores it performs a read-modify-write: read the target word, merge the low byte or halfword of register B into it, and write the result back. For full-word stores it writes B directly. It sits between the main control FSM (which issues `start`) and the memory port, and it owns the memory write strobe for the duration of a store.

## Interface
- `READ_LAT`, default 1: memory read latency in cycles, from the address being presented with `mem_wr`=0 to `mem_rdata` being valid; legal range 1–7.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  store request; sampled only in IDLE.
- `ss_type`  in  2  store size: 00 word, 01 byte, 10 halfword, 11 illegal; latched on accept.
- `addr`  in  32  target word address; latched on accept.
- `b_in`  in  32  store data (register B); latched on accept.
- `mem_rdata`  in  32  memory read data.
- `mem_addr`  out  32  memory address; equals latched address.
- `mem_wdata`  out  32  write data; meaningful only while `mem_wr`=1, otherwise 0.
- `mem_wr`  out  1  memory write strobe.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse, coincident with `done`, on illegal `ss_type`.

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: if `start`=1, latch `addr`, `b_in` and `ss_type`, then branch on the type:
  - 00 → WRITE.
  - 01 or 10 → READ.
  - 11 → DONE with the error flag set.
- READ: one cycle. `mem_wr`=0 and `mem_addr` is valid. Load the wait counter with `READ_LAT`-1, then go to WAIT.
- WAIT: hold while the counter is nonzero, decrementing each cycle. In the cycle where the counter is 0, capture `mem_rdata` into the old-word register and go to WRITE.
- WRITE: one cycle with `mem_wr`=1. `mem_wdata` depends on the latched type:
  - word: latched B.
  - byte: {old[31:8], B[7:0]}.
  - halfword: {old[31:16], B[15:0]}.
  - Then go to DONE.
- DONE: one cycle. `done`=1, and `err`=1 if the error flag is set. Clear the flag and return to IDLE.
- `start` outside IDLE is ignored; it is not queued.
- Input changes after accept have no effect; only the latched copies are used.
- `mem_addr` always reflects the latched address register.
- Byte and halfword merges always target the low bits of the word; `addr[1:0]` is passed through unmodified and not decoded.
- An illegal type never asserts `mem_wr`.

## Timing
- Reset values: state IDLE; all latched and old-word registers 0; `mem_addr`=0, `mem_wdata`=0, `mem_wr`=0, `busy`=0, `done`=0, `err`=0.
- All outputs are decoded from registered state and latches; no input-to-output combinational path.
- Latency is counted from the edge that samples `start` (end of cycle 0):
  - Word: WRITE in cycle 1, `done` in cycle 2.
  - Byte/halfword: READ in cycle 1, WAIT in cycles 2..1+`READ_LAT`, WRITE in cycle 2+`READ_LAT`, `done` in cycle 3+`READ_LAT`.
  - Illegal: `done`+`err` in cycle 1.
- Back-to-back: `start` held high in the DONE cycle is not accepted. The next accept occurs on the edge ending the first IDLE cycle.
- Reset mid-operation (any state) returns to IDLE on that edge. `mem_wr` is 0 the following cycle, no `done` pulse is issued, and the store is abandoned.
- Reset and `start` in the same cycle: reset wins and nothing is latched.

## Structure
- Shared package (`store_pkg`) holds:
  - the `ss_type` encodings (SS_WORD=2'b00, SS_BYTE=2'b01, SS_HALF=2'b10);
  - the state encoding (3 bits).
- `READ_LAT` width is 3 bits for the wait counter.
- One sub-module: `ss_merge`, a purely combinational merge of old word, B and type into write data.
- The FSM, latches and counter stay in the top module.

## Test plan
- Word store: `start`, type 00, addr 0x40, B 0xDEADBEEF → `mem_wr`=1 in cycle 1 with wdata 0xDEADBEEF and addr 0x40; `done` in cycle 2; no read cycle.
- Byte store, `READ_LAT`=1: memory holds 0x11223344, B 0xAABBCCDD → single write of 0x112233DD in cycle 3; `done` in cycle 4; `busy` high in cycles 1–4.
- Halfword store, `READ_LAT`=3: same data → write of 0x1122CCDD in cycle 5; `done` in cycle 6; `b_in` changed mid-operation has no effect.
- Illegal type 11 → `done`=`err`=1 in cycle 1; `mem_wr` never asserted.
- `start` held continuously across two byte stores → second accept only after the IDLE cycle following `done`; `start` pulses during `busy` are ignored.
- Reset asserted during WAIT → next cycle IDLE, all outputs 0, no `done`; a subsequent word store completes normally.
